// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : ID/EX register, forwarding operand muxes, 64-bit ALU and EX/MEM
//            register of a 5-stage 64-bit RISC-V pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcsrc,
    input  logic [7:0]  pc_in,
    input  logic [31:0] instr_in,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic [63:0] imm_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    input  logic [4:0]  rd_in,
    input  logic [7:0]  ctrl_in,
    input  logic [3:0]  alu_ctrl,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [63:0] wb_data,
    output logic [31:0] id_ex_instr,
    output logic [7:0]  id_ex_ctrl,
    output logic [4:0]  id_ex_rs1,
    output logic [4:0]  id_ex_rs2,
    output logic [4:0]  id_ex_rd,
    output logic [63:0] ex_mem_alu,
    output logic [63:0] ex_mem_store,
    output logic [7:0]  ex_mem_target,
    output logic        ex_mem_zero,
    output logic [4:0]  ex_mem_rd,
    output logic [4:0]  ex_mem_ctrl,
    output logic        alu_carry,
    output logic        alu_overflow
);

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_XOR = 4'b0011;
    localparam logic [3:0] c_ALU_SLL = 4'b0100;
    localparam logic [3:0] c_ALU_SRL = 4'b0101;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_SRA = 4'b1000;

    localparam logic [1:0] c_FWD_MEM = 2'b10;
    localparam logic [1:0] c_FWD_WB  = 2'b01;

    // ID/EX pipeline register
    logic [7:0]  r_id_ex_pc;
    logic [31:0] r_id_ex_instr;
    logic [63:0] r_id_ex_rs1_data;
    logic [63:0] r_id_ex_rs2_data;
    logic [63:0] r_id_ex_imm;
    logic [4:0]  r_id_ex_rs1;
    logic [4:0]  r_id_ex_rs2;
    logic [4:0]  r_id_ex_rd;
    logic [7:0]  r_id_ex_ctrl;

    // EX/MEM pipeline register
    logic [63:0] r_ex_mem_alu;
    logic [63:0] r_ex_mem_store;
    logic [7:0]  r_ex_mem_target;
    logic        r_ex_mem_zero;
    logic [4:0]  r_ex_mem_rd;
    logic [4:0]  r_ex_mem_ctrl;

    logic [63:0] w_op_a;
    logic [63:0] w_op_b_fwd;
    logic [63:0] w_alu_b;
    logic [5:0]  w_shamt;
    logic [64:0] w_sum;
    logic [64:0] w_diff;
    logic [63:0] w_result;
    logic        w_carry;
    logic        w_overflow;
    logic        w_zero;
    logic [7:0]  w_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_ex_pc       <= '0;
            r_id_ex_instr    <= '0;
            r_id_ex_rs1_data <= '0;
            r_id_ex_rs2_data <= '0;
            r_id_ex_imm      <= '0;
            r_id_ex_rs1      <= '0;
            r_id_ex_rs2      <= '0;
            r_id_ex_rd       <= '0;
            r_id_ex_ctrl     <= '0;
        end else if (pcsrc) begin
            r_id_ex_pc       <= '0;
            r_id_ex_instr    <= '0;
            r_id_ex_rs1_data <= '0;
            r_id_ex_rs2_data <= '0;
            r_id_ex_imm      <= '0;
            r_id_ex_rs1      <= '0;
            r_id_ex_rs2      <= '0;
            r_id_ex_rd       <= '0;
            r_id_ex_ctrl     <= '0;
        end else begin
            r_id_ex_pc       <= pc_in;
            r_id_ex_instr    <= instr_in;
            r_id_ex_rs1_data <= rs1_data;
            r_id_ex_rs2_data <= rs2_data;
            r_id_ex_imm      <= imm_in;
            r_id_ex_rs1      <= rs1_in;
            r_id_ex_rs2      <= rs2_in;
            r_id_ex_rd       <= rd_in;
            r_id_ex_ctrl     <= ctrl_in;
        end
    end

    // Select 11 falls through to the register-file value, same as 00.
    always_comb begin
        w_op_a = r_id_ex_rs1_data;
        case (fwd_a)
            c_FWD_MEM: w_op_a = r_ex_mem_alu;
            c_FWD_WB:  w_op_a = wb_data;
            default:   w_op_a = r_id_ex_rs1_data;
        endcase
    end

    always_comb begin
        w_op_b_fwd = r_id_ex_rs2_data;
        case (fwd_b)
            c_FWD_MEM: w_op_b_fwd = r_ex_mem_alu;
            c_FWD_WB:  w_op_b_fwd = wb_data;
            default:   w_op_b_fwd = r_id_ex_rs2_data;
        endcase
    end

    assign w_alu_b = r_id_ex_ctrl[2] ? r_id_ex_imm : w_op_b_fwd;
    assign w_shamt = w_alu_b[5:0];
    assign w_sum   = {1'b0, w_op_a} + {1'b0, w_alu_b};
    assign w_diff  = {1'b0, w_op_a} + {1'b0, ~w_alu_b} + 65'd1;

    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (alu_ctrl)
            c_ALU_AND: w_result = w_op_a & w_alu_b;
            c_ALU_OR:  w_result = w_op_a | w_alu_b;
            c_ALU_XOR: w_result = w_op_a ^ w_alu_b;
            c_ALU_ADD: begin
                w_result   = w_sum[63:0];
                w_carry    = w_sum[64];
                w_overflow = (w_op_a[63] == w_alu_b[63]) && (w_sum[63] != w_op_a[63]);
            end
            c_ALU_SUB: begin
                w_result   = w_diff[63:0];
                w_carry    = w_diff[64];
                w_overflow = (w_op_a[63] != w_alu_b[63]) && (w_diff[63] != w_op_a[63]);
            end
            c_ALU_SLL: w_result = w_op_a << w_shamt;
            c_ALU_SRL: w_result = w_op_a >> w_shamt;
            c_ALU_SRA: w_result = $signed(w_op_a) >>> w_shamt;
            c_ALU_SLT: w_result = {63'd0, $signed(w_op_a) < $signed(w_alu_b)};
            default:   w_result = '0;
        endcase
    end

    assign w_zero   = (w_result == 64'd0);
    assign w_target = r_id_ex_pc + r_id_ex_imm[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_mem_alu    <= '0;
            r_ex_mem_store  <= '0;
            r_ex_mem_target <= '0;
            r_ex_mem_zero   <= 1'b0;
            r_ex_mem_rd     <= '0;
            r_ex_mem_ctrl   <= '0;
        end else if (pcsrc) begin
            r_ex_mem_alu    <= '0;
            r_ex_mem_store  <= '0;
            r_ex_mem_target <= '0;
            r_ex_mem_zero   <= 1'b0;
            r_ex_mem_rd     <= '0;
            r_ex_mem_ctrl   <= '0;
        end else begin
            r_ex_mem_alu    <= w_result;
            r_ex_mem_store  <= w_op_b_fwd;
            r_ex_mem_target <= w_target;
            r_ex_mem_zero   <= w_zero;
            r_ex_mem_rd     <= r_id_ex_rd;
            r_ex_mem_ctrl   <= r_id_ex_ctrl[7:3];
        end
    end

    assign id_ex_instr   = r_id_ex_instr;
    assign id_ex_ctrl    = r_id_ex_ctrl;
    assign id_ex_rs1     = r_id_ex_rs1;
    assign id_ex_rs2     = r_id_ex_rs2;
    assign id_ex_rd      = r_id_ex_rd;
    assign ex_mem_alu    = r_ex_mem_alu;
    assign ex_mem_store  = r_ex_mem_store;
    assign ex_mem_target = r_ex_mem_target;
    assign ex_mem_zero   = r_ex_mem_zero;
    assign ex_mem_rd     = r_ex_mem_rd;
    assign ex_mem_ctrl   = r_ex_mem_ctrl;
    assign alu_carry     = w_carry;
    assign alu_overflow  = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Vector table plus scoreboard bench for execute_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clk;
    logic        rst_n;
    logic        pcsrc;
    logic [7:0]  pc_in;
    logic [31:0] instr_in;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [4:0]  rd_in;
    logic [7:0]  ctrl_in;
    logic [3:0]  alu_ctrl;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [63:0] wb_data;
    logic [31:0] id_ex_instr;
    logic [7:0]  id_ex_ctrl;
    logic [4:0]  id_ex_rs1;
    logic [4:0]  id_ex_rs2;
    logic [4:0]  id_ex_rd;
    logic [63:0] ex_mem_alu;
    logic [63:0] ex_mem_store;
    logic [7:0]  ex_mem_target;
    logic        ex_mem_zero;
    logic [4:0]  ex_mem_rd;
    logic [4:0]  ex_mem_ctrl;
    logic        alu_carry;
    logic        alu_overflow;

    execute_stage dut (
        .clk(clk), .rst_n(rst_n), .pcsrc(pcsrc), .pc_in(pc_in), .instr_in(instr_in),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_in(imm_in), .rs1_in(rs1_in),
        .rs2_in(rs2_in), .rd_in(rd_in), .ctrl_in(ctrl_in), .alu_ctrl(alu_ctrl),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .id_ex_instr(id_ex_instr),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .id_ex_rd(id_ex_rd), .ex_mem_alu(ex_mem_alu), .ex_mem_store(ex_mem_store),
        .ex_mem_target(ex_mem_target), .ex_mem_zero(ex_mem_zero), .ex_mem_rd(ex_mem_rd),
        .ex_mem_ctrl(ex_mem_ctrl), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [63:0] wb;
        logic [7:0]  pc;
        logic [4:0]  rd;
        logic [63:0] e_res;
        logic        e_zero;
        logic        e_carry;
        logic        e_ovf;
        logic [63:0] e_store;
        logic [7:0]  e_target;
    } vec_t;

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic [63:0] store;
        logic [7:0]  target;
        logic [4:0]  rd;
        logic [4:0]  ctrl5;
    } exp_t;

    localparam int c_NVEC = 16;
    localparam logic [7:0] c_R = 8'h42;
    localparam logic [7:0] c_I = 8'h44;
    localparam logic [7:0] c_S = 8'h0C;
    localparam logic [63:0] c_MSB = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t vecs [c_NVEC];
    int   nvec;
    exp_t sb_q [$];
    int   n_checks;
    int   n_fail;

    task automatic add_vec(input logic [7:0] ctrl, input logic [3:0] op,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                           input logic [1:0] fa, input logic [1:0] fb, input logic [63:0] wb,
                           input logic [7:0] pc, input logic [4:0] rd,
                           input logic [63:0] e_res, input logic e_zero, input logic e_carry,
                           input logic e_ovf, input logic [63:0] e_store, input logic [7:0] e_target);
        vec_t v;
        v.ctrl = ctrl; v.op = op; v.a = a; v.b = b; v.imm = imm;
        v.fa = fa; v.fb = fb; v.wb = wb; v.pc = pc; v.rd = rd;
        v.e_res = e_res; v.e_zero = e_zero; v.e_carry = e_carry; v.e_ovf = e_ovf;
        v.e_store = e_store; v.e_target = e_target;
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_id(input vec_t v, input int idx);
        pc_in    = v.pc;
        instr_in = 32'h0000_0013 | (32'(idx) << 12);
        rs1_data = v.a;
        rs2_data = v.b;
        imm_in   = v.imm;
        rs1_in   = 5'(idx + 1);
        rs2_in   = 5'(idx + 2);
        rd_in    = v.rd;
        ctrl_in  = v.ctrl;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_id_ex_instr"}, 64'(id_ex_instr), 64'd0);
        chk({tag, "_id_ex_ctrl"},  64'(id_ex_ctrl), 64'd0);
        chk({tag, "_id_ex_rd"},    64'(id_ex_rd), 64'd0);
        chk({tag, "_id_ex_rs1"},   64'(id_ex_rs1), 64'd0);
        chk({tag, "_id_ex_rs2"},   64'(id_ex_rs2), 64'd0);
        chk({tag, "_ex_mem_alu"},  ex_mem_alu, 64'd0);
        chk({tag, "_ex_mem_store"}, ex_mem_store, 64'd0);
        chk({tag, "_ex_mem_target"}, 64'(ex_mem_target), 64'd0);
        chk({tag, "_ex_mem_zero"}, 64'(ex_mem_zero), 64'd0);
        chk({tag, "_ex_mem_rd"},   64'(ex_mem_rd), 64'd0);
        chk({tag, "_ex_mem_ctrl"}, 64'(ex_mem_ctrl), 64'd0);
    endtask

    initial begin
        vec_t bubble;
        exp_t e;
        exp_t got;
        n_checks = 0;
        n_fail   = 0;
        nvec     = 0;
        bubble   = '0;

        //      ctrl op     a              b         imm       fa fb wb      pc     rd  res                    z c o  store      target
        add_vec(c_I, 4'h2, 64'd5,         64'h11,   -64'sd3,  0, 0, 0,     8'h10, 1,  64'd2,                 0,1,0, 64'h11,    8'h0D);
        add_vec(c_R, 4'h6, 64'd7,         64'd7,    64'd16,   0, 0, 0,     8'd8,  2,  64'd0,                 1,1,0, 64'd7,     8'd24);
        add_vec(c_R, 4'h2, c_MSB - 64'd1, 64'd1,    64'd0,    0, 0, 0,     8'd0,  3,  c_MSB,                 0,0,1, 64'd1,     8'd0);
        add_vec(c_R, 4'h1, 64'd8,         64'd1,    64'd0,    0, 0, 0,     8'd1,  4,  64'd9,                 0,0,0, 64'd1,     8'd1);
        add_vec(c_R, 4'h2, 64'hAA,        64'hBB,   64'd0,    2, 1, 64'd4, 8'd2,  5,  64'd13,                0,0,0, 64'd4,     8'd2);
        add_vec(c_S, 4'h2, 64'd2,         64'hBB,   64'h100,  0, 1, 64'd4, 8'h20, 6,  64'h102,               0,0,0, 64'd4,     8'h20);
        add_vec(c_I, 4'h8, c_MSB,         64'd0,    64'd4,    0, 0, 0,     8'd0,  7,  64'hF800_0000_0000_0000, 0,0,0, 64'd0,  8'd4);
        add_vec(c_R, 4'h7, c_ONES,        64'd1,    64'd0,    0, 0, 0,     8'd3,  8,  64'd1,                 0,0,0, 64'd1,     8'd3);
        add_vec(c_I, 4'h4, 64'd1,         64'd0,    64'h43,   0, 0, 0,     8'd0,  9,  64'd8,                 0,0,0, 64'd0,     8'h43);
        add_vec(c_R, 4'h5, c_MSB,         64'h44,   64'd0,    0, 0, 0,     8'd4,  10, 64'h0800_0000_0000_0000, 0,0,0, 64'h44, 8'd4);
        add_vec(c_R, 4'h3, 64'hFF,        64'h0F,   64'd0,    0, 0, 0,     8'd5,  11, 64'hF0,                0,0,0, 64'h0F,    8'd5);
        add_vec(c_R, 4'h0, 64'hF0,        64'h3C,   64'd0,    0, 0, 0,     8'd6,  12, 64'h30,                0,0,0, 64'h3C,    8'd6);
        add_vec(c_R, 4'h6, 64'd3,         64'd5,    64'd0,    0, 0, 0,     8'd7,  13, c_ONES - 64'd1,        0,0,0, 64'd5,     8'd7);
        add_vec(c_R, 4'h6, c_MSB,         64'd1,    64'd0,    0, 0, 0,     8'd8,  14, c_MSB - 64'd1,         0,1,1, 64'd1,     8'd8);
        add_vec(c_R, 4'hF, 64'd5,         64'd5,    64'd0,    0, 0, 0,     8'd9,  15, 64'd0,                 1,0,0, 64'd5,     8'd9);
        add_vec(c_R, 4'h2, 64'd1,         64'd2,    64'd0,    3, 3, 64'h100, 8'd10, 16, 64'd3,               0,0,0, 64'd2,     8'd10);

        rst_n = 1'b0;
        pcsrc = 1'b0;
        drive_id(bubble, 0);
        instr_in = '0; rs1_in = '0; rs2_in = '0;
        alu_ctrl = '0; fwd_a = '0; fwd_b = '0; wb_data = '0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k <= nvec; k++) begin
            @(negedge clk);
            if (k < nvec) begin
                drive_id(vecs[k], k);
                e.res = vecs[k].e_res; e.zero = vecs[k].e_zero; e.store = vecs[k].e_store;
                e.target = vecs[k].e_target; e.rd = vecs[k].rd; e.ctrl5 = vecs[k].ctrl[7:3];
                sb_q.push_back(e);
            end else begin
                drive_id(bubble, 0);
            end
            if (k >= 1) begin
                alu_ctrl = vecs[k-1].op;
                fwd_a    = vecs[k-1].fa;
                fwd_b    = vecs[k-1].fb;
                wb_data  = vecs[k-1].wb;
                #1;
                chk($sformatf("v%0d_carry", k-1), 64'(alu_carry), 64'(vecs[k-1].e_carry));
                chk($sformatf("v%0d_overflow", k-1), 64'(alu_overflow), 64'(vecs[k-1].e_ovf));
                chk($sformatf("v%0d_id_ex_rd", k-1), 64'(id_ex_rd), 64'(vecs[k-1].rd));
                chk($sformatf("v%0d_id_ex_ctrl", k-1), 64'(id_ex_ctrl), 64'(vecs[k-1].ctrl));
                chk($sformatf("v%0d_id_ex_instr", k-1), 64'(id_ex_instr),
                    64'(32'h0000_0013 | (32'(k-1) << 12)));
            end
            @(posedge clk);
            #1;
            if (k >= 1) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard_empty: got 0 entries, expected 1");
                end else begin
                    got = sb_q.pop_front();
                    chk($sformatf("v%0d_ex_mem_alu", k-1), ex_mem_alu, got.res);
                    chk($sformatf("v%0d_ex_mem_zero", k-1), 64'(ex_mem_zero), 64'(got.zero));
                    chk($sformatf("v%0d_ex_mem_store", k-1), ex_mem_store, got.store);
                    chk($sformatf("v%0d_ex_mem_target", k-1), 64'(ex_mem_target), 64'(got.target));
                    chk($sformatf("v%0d_ex_mem_rd", k-1), 64'(ex_mem_rd), 64'(got.rd));
                    chk($sformatf("v%0d_ex_mem_ctrl", k-1), 64'(ex_mem_ctrl), 64'(got.ctrl5));
                end
            end
        end

        // Flush: store/write instruction in EX and another in ID when pcsrc hits.
        @(negedge clk);
        alu_ctrl = 4'h2; fwd_a = 2'b00; fwd_b = 2'b00;
        pc_in = 8'd40; instr_in = 32'hDEAD_0023; rs1_data = 64'd1; rs2_data = 64'd2;
        imm_in = 64'd1; rs1_in = 5'd3; rs2_in = 5'd4; rd_in = 5'd7; ctrl_in = 8'h4C;
        @(posedge clk);
        #1;
        chk("flush_pre_id_ex_ctrl", 64'(id_ex_ctrl), 64'h4C);
        @(negedge clk);
        rd_in = 5'd8;
        pcsrc = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_id_ex_ctrl", 64'(id_ex_ctrl), 64'd0);
        chk("flush_id_ex_rd", 64'(id_ex_rd), 64'd0);
        chk("flush_ex_mem_ctrl", 64'(ex_mem_ctrl), 64'd0);
        chk("flush_ex_mem_rd", 64'(ex_mem_rd), 64'd0);
        chk("flush_ex_mem_alu", ex_mem_alu, 64'd0);

        // Asynchronous reset between edges.
        @(negedge clk);
        pcsrc = 1'b0;
        rd_in = 5'd9;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("prerst_ex_mem_ctrl", 64'(ex_mem_ctrl), 64'h09);
        chk("prerst_ex_mem_rd", 64'(ex_mem_rd), 64'd9);
        chk("prerst_ex_mem_alu", ex_mem_alu, 64'd2);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
